// File: rtl/sdm_stream_ctrl.sv
// sdm_stream_ctrl: sample-rate scheduler and PCM stream buffer in front of the SDM DAC/ADC
// clk, rst_n        : clock, asynchronous active-low reset
// enable            : run converters (1) or stop with drain (0)
// s_valid/s_ready/s_data       : host PCM samples into the input FIFO
// dac_valid/dac_data           : DAC enable and sample, updated once per tick
// adc_valid                    : ADC enable
// adc_res_valid/adc_res_data   : ADC decimated result, captured on tick
// m_valid/m_ready/m_data       : captured ADC sample to host
// state, fifo_level, underflow_cnt, overflow_cnt : status
module sdm_stream_ctrl #(
  parameter int DW        = 16,
  parameter int OSR       = 64,
  parameter int DEPTH     = 8,
  parameter int PRIME_LVL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DW-1:0]          s_data,
  output logic                   dac_valid,
  output logic [DW-1:0]          dac_data,
  output logic                   adc_valid,
  input  logic                   adc_res_valid,
  input  logic [DW-1:0]          adc_res_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DW-1:0]          m_data,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             underflow_cnt,
  output logic [7:0]             overflow_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OSR);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  state_t st, st_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic active, tick, empty, push, pop, cap;
  assign active = st == RUN || st == DRAIN;
  assign tick = active && cnt == CW'(OSR - 1);
  assign fifo_level = wr_ptr - rd_ptr;
  assign empty = fifo_level == '0;
  assign s_ready = fifo_level != (AW + 1)'(DEPTH);
  assign push = s_valid && s_ready;
  assign pop = tick && !empty;
  assign cap = tick && adc_res_valid;
  assign state = st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_nxt;
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:  st_nxt = enable ? PRIME : IDLE;
      PRIME: st_nxt = !enable ? IDLE : fifo_level >= (AW + 1)'(PRIME_LVL) ? RUN : PRIME;
      RUN:   st_nxt = enable ? RUN : DRAIN;
      DRAIN: st_nxt = enable ? RUN : tick && empty ? IDLE : DRAIN;
    endcase
  end
  always_comb begin
    dac_valid = active;
    adc_valid = active;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      dac_data      <= '0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      underflow_cnt <= '0;
      overflow_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= active && !tick ? cnt + 1'b1 : '0;
      if (tick) dac_data <= empty ? '0 : mem[rd_ptr[AW-1:0]];
      if (tick && empty && st == RUN && underflow_cnt != 8'hff) underflow_cnt <= underflow_cnt + 1'b1;
      if (cap && m_valid && !m_ready && overflow_cnt != 8'hff) overflow_cnt <= overflow_cnt + 1'b1;
      if (cap) begin
        m_valid <= 1'b1;
        m_data  <= adc_res_data;
      end else if (m_ready) m_valid <= 1'b0;
    end
endmodule
